fifo_read_ctrl: RTL and testbench

Read-domain controller for the two-flop-synchronised asynchronous FIFO. It owns the read pointer and brings the Gray-coded write pointer into r_clk through a two-flop synchroniser. It generates the read address and the registered empty flag that drive the dual-port memory's read port, plus an almost-empty flag and a conservative occupancy count. It is the reader-side counterpart of the write-domain pointer/full logic and of the memory write port.

---
 rtl/fifo_read_ctrl.sv | 147 ++++++++++++++
 tb/tb_fifo_read_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/fifo_read_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_read_ctrl
//
// Read-domain half of a dual-clock FIFO. It keeps the binary and Gray read
// pointers and brings the Gray write pointer into r_clk through a two-flop
// synchroniser. From these it produces:
//   - the memory read address,
//   - a registered empty flag,
//   - an almost-empty flag,
//   - a conservative occupancy count,
//   - an underflow pulse.
//
// Parameters
//   Address   memory address width; depth = 2**Address, pointers Address+1 bits
//   AE_LEVEL  almost_empty is high while r_level <= AE_LEVEL (0..2**Address-1)
//
// Ports
//   r_clk         read clock, the only clock of this block
//   r_rst         asynchronous active-high reset
//   r_en          read request from the consumer
//   wptr_gray     Gray write pointer from the write domain (asynchronous)
//   r_addr        read address to the memory read port
//   rptr_gray     registered Gray read pointer, returned to the write domain
//   empty         registered empty flag; also gates the memory read port
//   almost_empty  registered, high when r_level <= AE_LEVEL
//   r_level       registered occupancy as seen from the read side
//   r_underflow   one-cycle pulse for each cycle r_en is high while empty
// -----------------------------------------------------------------------------
module fifo_read_ctrl #(
  parameter int Address  = 4,
  parameter int AE_LEVEL = 1
) (
  input  logic               r_clk,
  input  logic               r_rst,
  input  logic               r_en,
  input  logic [Address:0]   wptr_gray,
  output logic [Address-1:0] r_addr,
  output logic [Address:0]   rptr_gray,
  output logic               empty,
  output logic               almost_empty,
  output logic [Address:0]   r_level,
  output logic               r_underflow
);

  localparam int PW = Address + 1;
  localparam logic [Address:0] AE_THRESH = PW'(AE_LEVEL);

  // Pointer and flag state
  logic [Address:0] rbin_q;
  logic [Address:0] rptr_gray_q;
  logic [Address:0] wq1_q;
  logic [Address:0] wq2_q;
  logic [Address:0] r_level_q;
  logic             empty_q;
  logic             almost_empty_q;
  logic             r_underflow_q;

  // Next-state values
  logic             rd_fire;
  logic [Address:0] rbin_d;
  logic [Address:0] rgray_d;
  logic [Address:0] wbin_s;
  logic [Address:0] level_d;
  logic             empty_d;
  logic             almost_empty_d;
  logic             r_underflow_d;

  // Gray-to-binary of the synchronised write pointer. Each binary bit is the
  // XOR of all Gray bits from the MSB down to that position.
  generate
    for (genvar gi = 0; gi <= Address; gi++) begin : g_g2b
      assign wbin_s[gi] = ^wq2_q[Address:gi];
    end
  endgenerate

  always_comb begin
    rd_fire        = 1'b0;
    rbin_d         = rbin_q;
    rgray_d        = rptr_gray_q;
    level_d        = r_level_q;
    empty_d        = empty_q;
    almost_empty_d = almost_empty_q;
    r_underflow_d  = 1'b0;

    // The registered empty is used here, not a combinational flag. A read
    // only proceeds when the previous cycle already proved data present.
    rd_fire = r_en & ~empty_q;

    // The binary pointer wraps naturally at 2**(Address+1). The extra MSB
    // distinguishes laps, so equal pointers always mean empty.
    rbin_d  = rbin_q + {{Address{1'b0}}, rd_fire};
    rgray_d = rbin_d ^ (rbin_d >> 1);

    // Comparing the post-read pointer has two effects. Reading the last
    // word raises empty on the same edge. A write that reached wq2 in time
    // keeps empty low.
    empty_d = (rgray_d == wq2_q);

    // wbin_s lags the true write pointer, so this occupancy can only
    // understate what is really stored.
    level_d        = wbin_s - rbin_d;
    almost_empty_d = (level_d <= AE_THRESH);

    r_underflow_d = r_en & empty_q;
  end

  // wptr_gray changes one bit at a time. Either flop may go metastable on
  // that bit, but it settles to the old or the new pointer. It never settles
  // to an unrelated value.
  always_ff @(posedge r_clk or posedge r_rst) begin
    if (r_rst) begin
      wq1_q <= '0;
      wq2_q <= '0;
    end else begin
      wq1_q <= wptr_gray;
      wq2_q <= wq1_q;
    end
  end

  always_ff @(posedge r_clk or posedge r_rst) begin
    if (r_rst) begin
      rbin_q         <= '0;
      rptr_gray_q    <= '0;
      r_level_q      <= '0;
      empty_q        <= 1'b1;
      almost_empty_q <= 1'b1;
      r_underflow_q  <= 1'b0;
    end else begin
      rbin_q         <= rbin_d;
      rptr_gray_q    <= rgray_d;
      r_level_q      <= level_d;
      empty_q        <= empty_d;
      almost_empty_q <= almost_empty_d;
      r_underflow_q  <= r_underflow_d;
    end
  end

  // The memory captures data at the edge where rd_fire is high, using the
  // address presented before that edge. The address then moves on.
  assign r_addr       = rbin_q[Address-1:0];
  assign rptr_gray    = rptr_gray_q;
  assign empty        = empty_q;
  assign almost_empty = almost_empty_q;
  assign r_level      = r_level_q;
  assign r_underflow  = r_underflow_q;

endmodule

// File: tb/tb_fifo_read_ctrl.sv
module tb_fifo_read_ctrl;
  localparam int AW  = 4;
  localparam int AEL = 1;
  localparam int DEPTH = 1 << AW;
  localparam int PMOD  = 2 * DEPTH;

  logic          r_clk = 1'b0;
  logic          r_rst = 1'b1;
  logic          r_en = 1'b0;
  logic [AW:0]   wptr_gray = '0;
  logic [AW-1:0] r_addr;
  logic [AW:0]   rptr_gray;
  logic          empty, almost_empty, r_underflow;
  logic [AW:0]   r_level;

  fifo_read_ctrl #(.Address(AW), .AE_LEVEL(AEL)) dut (
    .r_clk(r_clk), .r_rst(r_rst), .r_en(r_en), .wptr_gray(wptr_gray),
    .r_addr(r_addr), .rptr_gray(rptr_gray), .empty(empty),
    .almost_empty(almost_empty), .r_level(r_level), .r_underflow(r_underflow)
  );

  always #5 r_clk = ~r_clk;

  int errors = 0;
  int checks = 0;

  // Reference model, kept as plain counts.
  // w_cnt: words written so far.
  // rd_cnt: words actually read.
  // seen1/seen2: write counts seen by the read side one and two edges ago.
  int w_cnt, rd_cnt, seen1, seen2, m_level;
  bit m_empty, m_ae, m_uf;

  function automatic logic [AW:0] to_gray(input int n);
    logic [AW:0] b;
    b = AW'(0) + (AW+1)'(n % PMOD);
    return b ^ (b >> 1);
  endfunction

  task automatic model_reset();
    w_cnt = 0; rd_cnt = 0; seen1 = 0; seen2 = 0;
    m_level = 0; m_empty = 1; m_ae = 1; m_uf = 0;
  endtask

  // One read-clock cycle. The write pointer moves to count wnew, and r_en
  // is set to ren. Outputs are sampled 1 time unit after the edge.
  task automatic tick(input bit ren, input int wnew);
    bit fire;
    r_en = ren;
    w_cnt = wnew;
    wptr_gray = to_gray(wnew);
    @(posedge r_clk);
    fire = ren && !m_empty;
    m_uf = ren && m_empty;
    if (fire) rd_cnt++;
    // Write progress becomes usable only after two synchroniser samples.
    m_level = ((seen2 - rd_cnt) % PMOD + PMOD) % PMOD;
    m_empty = (m_level == 0);
    m_ae = (m_level <= AEL);
    seen2 = seen1;
    seen1 = wnew;
    #1;
  endtask

  task automatic test_reset();
    model_reset();
    r_rst = 1'b1; r_en = 1'b0; wptr_gray = '0;
    #12;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%0b exp=1", empty); end
    checks++; if (almost_empty !== 1'b1) begin errors++; $display("FAIL reset_ae got=%0b exp=1", almost_empty); end
    checks++; if (r_level !== 5'd0) begin errors++; $display("FAIL reset_level got=%0d exp=0", r_level); end
    checks++; if (rptr_gray !== 5'd0 || r_addr !== 4'd0) begin errors++; $display("FAIL reset_ptr got=%0h/%0h exp=0/0", rptr_gray, r_addr); end
    @(posedge r_clk); #1 r_rst = 1'b0;
    tick(0, 0);
    tick(1, 0);
    checks++; if (r_underflow !== 1'b1) begin errors++; $display("FAIL idle_uf got=%0b exp=1", r_underflow); end
    checks++; if (r_addr !== 4'd0 || empty !== 1'b1) begin errors++; $display("FAIL idle_addr got=%0d/%0b exp=0/1", r_addr, empty); end
    tick(0, 0);
    checks++; if (r_underflow !== 1'b0) begin errors++; $display("FAIL idle_uf_clear got=%0b exp=0", r_underflow); end
    $display("test_reset done rd=%0d wr=%0d", rd_cnt, w_cnt);
  endtask

  task automatic test_first_write();
    tick(0, 1);
    tick(0, 1);
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL fw_early_empty got=%0b exp=1", empty); end
    tick(0, 1);
    checks++; if (empty !== 1'b0 || r_level !== 5'd1) begin errors++; $display("FAIL fw_visible got=%0b/%0d exp=0/1", empty, r_level); end
    tick(1, 1);
    checks++; if (r_addr !== 4'd1 || rptr_gray !== 5'b00001 || empty !== 1'b1) begin
      errors++; $display("FAIL fw_read got=%0d/%b/%0b exp=1/00001/1", r_addr, rptr_gray, empty);
    end
    $display("test_first_write done rd=%0d wr=%0d", rd_cnt, w_cnt);
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 5; i++) tick(0, w_cnt + 1);
    for (int i = 0; i < 3; i++) tick(0, w_cnt);
    checks++; if (r_level !== 5'(m_level) || m_level != 5) begin errors++; $display("FAIL ar_level got=%0d exp=5", r_level); end
    #2 r_rst = 1'b1;
    #1;
    checks++; if (empty !== 1'b1 || rptr_gray !== 5'd0 || r_level !== 5'd0 || almost_empty !== 1'b1) begin
      errors++; $display("FAIL ar_immediate got e=%0b g=%b l=%0d ae=%0b exp 1/00000/0/1", empty, rptr_gray, r_level, almost_empty);
    end
    model_reset();
    wptr_gray = '0; r_en = 1'b0;
    @(posedge r_clk); #1 r_rst = 1'b0;
    tick(1, 0);
    checks++; if (r_underflow !== 1'b1 || r_addr !== 4'd0 || empty !== 1'b1) begin
      errors++; $display("FAIL ar_after uf=%0b addr=%0d e=%0b exp 1/0/1", r_underflow, r_addr, empty);
    end
    tick(0, 0);
    $display("test_async_reset done rd=%0d wr=%0d", rd_cnt, w_cnt);
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < DEPTH; i++) tick(0, w_cnt + 1);
    for (int i = 0; i < 3; i++) tick(0, w_cnt);
    checks++; if (r_level !== 5'd16 || almost_empty !== 1'b0 || empty !== 1'b0) begin
      errors++; $display("FAIL fill_level got=%0d ae=%0b e=%0b exp 16/0/0", r_level, almost_empty, empty);
    end
    for (int i = 0; i < DEPTH - 1; i++) begin
      tick(1, w_cnt);
      checks++; if (almost_empty !== m_ae || r_level !== 5'(m_level)) begin
        errors++; $display("FAIL drain_ae got=%0b/%0d exp=%0b/%0d", almost_empty, r_level, m_ae, m_level);
      end
    end
    checks++; if (r_level !== 5'd1 || almost_empty !== 1'b1 || empty !== 1'b0) begin
      errors++; $display("FAIL drain_last1 got=%0d/%0b/%0b exp 1/1/0", r_level, almost_empty, empty);
    end
    tick(1, w_cnt);
    checks++; if (empty !== 1'b1 || rptr_gray !== 5'b11000 || r_addr !== 4'd0) begin
      errors++; $display("FAIL drain_empty got=%0b/%b/%0d exp 1/11000/0", empty, rptr_gray, r_addr);
    end
    $display("test_fill_drain done rd=%0d wr=%0d", rd_cnt, w_cnt);
  endtask

  task automatic test_wrap();
    for (int i = 0; i < DEPTH; i++) tick(0, w_cnt + 1);
    for (int i = 0; i < 3; i++) tick(0, w_cnt);
    for (int i = 0; i < DEPTH; i++) begin
      if (i == DEPTH - 1) begin
        checks++; if (r_addr !== 4'd15 || rptr_gray !== 5'b10000) begin
          errors++; $display("FAIL wrap_pre got=%0d/%b exp 15/10000", r_addr, rptr_gray);
        end
      end
      tick(1, w_cnt);
      checks++; if (r_addr !== 4'(rd_cnt % DEPTH)) begin errors++; $display("FAIL wrap_addr got=%0d exp=%0d", r_addr, rd_cnt % DEPTH); end
    end
    checks++; if (rptr_gray !== 5'b00000 || empty !== 1'b1 || r_addr !== 4'd0) begin
      errors++; $display("FAIL wrap_end got=%b/%0b/%0d exp 00000/1/0", rptr_gray, empty, r_addr);
    end
    $display("test_wrap done rd=%0d wr=%0d", rd_cnt, w_cnt);
  endtask

  task automatic test_last_word_race();
    tick(0, w_cnt + 1);
    for (int i = 0; i < 3; i++) tick(0, w_cnt);
    tick(0, w_cnt + 1);
    tick(0, w_cnt);
    checks++; if (r_level !== 5'd1 || empty !== 1'b0) begin errors++; $display("FAIL race_pre got=%0d/%0b exp 1/0", r_level, empty); end
    tick(1, w_cnt);
    checks++; if (empty !== 1'b0 || r_level !== 5'd1 || r_underflow !== 1'b0) begin
      errors++; $display("FAIL race got e=%0b l=%0d uf=%0b exp 0/1/0", empty, r_level, r_underflow);
    end
    tick(1, w_cnt);
    checks++; if (empty !== 1'b1 || r_level !== 5'd0) begin errors++; $display("FAIL race_drain got=%0b/%0d exp 1/0", empty, r_level); end
    $display("test_last_word_race done rd=%0d wr=%0d", rd_cnt, w_cnt);
  endtask

  task automatic test_random();
    bit ren, wr;
    for (int i = 0; i < 400; i++) begin
      ren = ($urandom_range(0, 2) != 0);
      wr  = ($urandom_range(0, 1) == 1) && ((w_cnt - rd_cnt) < DEPTH);
      tick(ren, w_cnt + int'(wr));
      $display("rnd cyc=%0d ren=%0b wr=%0b rd=%0d wcnt=%0d lvl=%0d", i, ren, wr, rd_cnt, w_cnt, r_level);
      checks++; if (empty !== m_empty) begin errors++; $display("FAIL rnd_empty cyc=%0d got=%0b exp=%0b", i, empty, m_empty); end
      checks++; if (almost_empty !== m_ae) begin errors++; $display("FAIL rnd_ae cyc=%0d got=%0b exp=%0b", i, almost_empty, m_ae); end
      checks++; if (r_level !== 5'(m_level)) begin errors++; $display("FAIL rnd_level cyc=%0d got=%0d exp=%0d", i, r_level, m_level); end
      checks++; if (r_underflow !== m_uf) begin errors++; $display("FAIL rnd_uf cyc=%0d got=%0b exp=%0b", i, r_underflow, m_uf); end
      checks++; if (r_addr !== 4'(rd_cnt % DEPTH)) begin errors++; $display("FAIL rnd_addr cyc=%0d got=%0d exp=%0d", i, r_addr, rd_cnt % DEPTH); end
      checks++; if (rptr_gray !== to_gray(rd_cnt)) begin errors++; $display("FAIL rnd_gray cyc=%0d got=%b exp=%b", i, rptr_gray, to_gray(rd_cnt)); end
      checks++; if (m_level > w_cnt - rd_cnt) begin errors++; $display("FAIL rnd_overstate cyc=%0d got=%0d max=%0d", i, m_level, w_cnt - rd_cnt); end
    end
    $display("test_random done rd=%0d wr=%0d", rd_cnt, w_cnt);
  endtask

  initial begin
    test_reset();
    test_first_write();
    test_async_reset();
    test_fill_drain();
    test_wrap();
    test_last_word_race();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule
